// File: rtl/graph_pkg.sv
// Shared constants and types for the edge-list RAM and the blocks that use it.
package graph_pkg;

   localparam int EDGE_NUM  = 1034;
   localparam int POSE_NUM  = 66;
   localparam int ADDR_W    = 11;
   localparam int DATA_W    = 16;

   localparam int REQ_HOST  = 0;
   localparam int REQ_COLL  = 1;
   localparam int REQ_GRAPH = 2;

   // Edge word layout: {firstPose, secondPose}
   localparam int FIRST_POSE_MSB  = 15;
   localparam int FIRST_POSE_LSB  = 8;
   localparam int SECOND_POSE_MSB = 7;
   localparam int SECOND_POSE_LSB = 0;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lockState_t;

endpackage

// File: rtl/edge_ram_arbiter_if.sv
// Requester-side bus of the edge RAM arbiter: packed per-requester request
// fields going in, one-hot grant/read-valid and shared read data coming back.
interface edge_ram_arbiter_if #(
   parameter int N_REQ  = 3,
   parameter int ADDR_W = 11,
   parameter int DATA_W = 16
);

   logic [N_REQ-1:0]        req;
   logic [N_REQ-1:0]        lock;
   logic [N_REQ-1:0]        we;
   logic [N_REQ*ADDR_W-1:0] addr;
   logic [N_REQ*DATA_W-1:0] wdata;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        rvalid;
   logic [DATA_W-1:0]       rdata;

   modport master (
      output req, lock, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, lock, we, addr, wdata,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: picks the first set request bit
// starting just after the previous owner and wrapping around.
module rr_pick #(
   parameter int N_REQ = 3,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] lastOwner,
   output logic [N_REQ-1:0] gntOnehot
);

   logic             found;
   logic [IDX_W-1:0] idx;

   // Walk the requesters in priority order lastOwner+1 .. lastOwner+N_REQ.
   always_comb begin
      gntOnehot = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = IDX_W'((32'(lastOwner) + 32'(k)) % 32'(N_REQ));
         if (!found && req[idx]) begin
            gntOnehot[idx] = 1'b1;
            found          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/edge_ram_arbiter.sv
// Single-port edge-list RAM arbiter: round-robin between requesters, with a
// lock so one requester can sweep the RAM without being interleaved.
module edge_ram_arbiter #(
   parameter int N_REQ    = 3,
   parameter int ADDR_W   = graph_pkg::ADDR_W,
   parameter int DATA_W   = graph_pkg::DATA_W,
   parameter int EDGE_NUM = graph_pkg::EDGE_NUM,
   parameter int LOCK_MAX = 2048
) (
   input  logic              CLK,
   input  logic              RST_n,
   edge_ram_arbiter_if.slave bus,
   output logic              addr_err,
   output logic              lock_timeout,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   import graph_pkg::*;

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

   lockState_t        lockState, stateNext;
   logic [IDX_W-1:0]  lockOwner, ownerNext;
   logic [CNT_W-1:0]  lockCnt, cntNext;
   logic              timeoutNext;

   logic [IDX_W-1:0]  lastOwner;
   logic [N_REQ-1:0]  rrGnt;
   logic [N_REQ-1:0]  gnt;
   logic [IDX_W-1:0]  gIdx;
   logic              granted;
   logic              effLocked;
   logic              illegal;

   logic [ADDR_W-1:0] addrArr  [N_REQ];
   logic [DATA_W-1:0] wdataArr [N_REQ];
   logic [ADDR_W-1:0] selAddr;
   logic [DATA_W-1:0] selWdata;
   logic              selWe;
   logic              selLock;

   logic [N_REQ-1:0]  rvalidQ;
   logic              addrErrQ;
   logic              timeoutQ;

   for (genvar i = 0; i < N_REQ; i++) begin : gUnpack
      assign addrArr[i]  = bus.addr[i*ADDR_W +: ADDR_W];
      assign wdataArr[i] = bus.wdata[i*DATA_W +: DATA_W];
   end

   rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) uRrPick (
      .req       (bus.req),
      .lastOwner (lastOwner),
      .gntOnehot (rrGnt)
   );

   // A lock whose owner has just dropped its lock bit no longer counts, so
   // the release takes effect before anyone else is arbitrated this cycle.
   assign effLocked = (lockState == LOCKED) && bus.lock[lockOwner];

   // Grant selection: a live lock owner that is requesting wins outright,
   // otherwise round-robin; nothing is granted while reset is held.
   always_comb begin
      gnt = '0;
      if (RST_n) begin
         if (effLocked && bus.req[lockOwner]) begin
            gnt[lockOwner] = 1'b1;
         end else begin
            gnt = rrGnt;
         end
      end
   end

   // Convert the one-hot grant into an index and select that requester's access.
   always_comb begin
      gIdx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            gIdx = IDX_W'(i);
         end
      end
   end

   assign granted  = |gnt;
   assign selAddr  = addrArr[gIdx];
   assign selWdata = wdataArr[gIdx];
   assign selWe    = bus.we[gIdx];
   assign selLock  = bus.lock[gIdx];
   assign illegal  = 32'(selAddr) >= 32'(EDGE_NUM);

   // Illegal addresses still receive gnt so the requester never stalls, but
   // the RAM itself is left untouched.
   assign ram_en    = granted && !illegal;
   assign ram_we    = granted && !illegal && selWe;
   assign ram_addr  = granted ? selAddr  : '0;
   assign ram_wdata = granted ? selWdata : '0;

   // Lock FSM next state: voluntary release may hand the lock straight to a
   // newly granted locker; a forced release never does.
   always_comb begin
      stateNext   = lockState;
      ownerNext   = lockOwner;
      cntNext     = lockCnt;
      timeoutNext = 1'b0;
      case (lockState)
         UNLOCKED: begin
            if (granted && selLock) begin
               stateNext = LOCKED;
               ownerNext = gIdx;
               cntNext   = '0;
            end
         end
         LOCKED: begin
            if (!bus.lock[lockOwner]) begin
               stateNext = UNLOCKED;
               cntNext   = '0;
               if (granted && selLock) begin
                  stateNext = LOCKED;
                  ownerNext = gIdx;
               end
            end else if (lockCnt == CNT_W'(LOCK_MAX - 1)) begin
               stateNext   = UNLOCKED;
               cntNext     = '0;
               timeoutNext = 1'b1;
            end else begin
               cntNext = lockCnt + CNT_W'(1);
            end
         end
         default: begin
            stateNext = UNLOCKED;
            cntNext   = '0;
         end
      endcase
   end

   // Lock FSM state register.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         lockState <= UNLOCKED;
         lockOwner <= '0;
         lockCnt   <= '0;
      end else begin
         lockState <= stateNext;
         lockOwner <= ownerNext;
         lockCnt   <= cntNext;
      end
   end

   // Round-robin history and the one-cycle-late status flags.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         lastOwner <= IDX_W'(N_REQ - 1);
         rvalidQ   <= '0;
         addrErrQ  <= 1'b0;
         timeoutQ  <= 1'b0;
      end else begin
         if (granted) begin
            lastOwner <= gIdx;
         end
         rvalidQ  <= (ram_en && !selWe) ? gnt : '0;
         addrErrQ <= granted && illegal;
         timeoutQ <= timeoutNext;
      end
   end

   // Masking with RST_n drops a read return that was already in flight when
   // reset was asserted.
   assign bus.gnt      = gnt;
   assign bus.rvalid   = rvalidQ & {N_REQ{RST_n}};
   assign bus.rdata    = ram_rdata;
   assign addr_err     = addrErrQ & RST_n;
   assign lock_timeout = timeoutQ & RST_n;

endmodule

// File: tb/tb_edge_ram_arbiter.sv
// Self-checking bench for edge_ram_arbiter: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_edge_ram_arbiter;

   import graph_pkg::*;

   localparam int N        = 3;
   localparam int LOCK_MAX = 2048;

   logic              CLK = 1'b0;
   logic              RST_n = 1'b0;
   logic              addrErr, lockTimeout, ramEn, ramWe;
   logic [ADDR_W-1:0] ramAddr;
   logic [DATA_W-1:0] ramWdata;
   logic [DATA_W-1:0] ramRdata;

   edge_ram_arbiter_if #(.N_REQ(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   edge_ram_arbiter #(
      .N_REQ(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .EDGE_NUM(EDGE_NUM), .LOCK_MAX(LOCK_MAX)
   ) dut (
      .CLK          (CLK),
      .RST_n        (RST_n),
      .bus          (bus),
      .addr_err     (addrErr),
      .lock_timeout (lockTimeout),
      .ram_en       (ramEn),
      .ram_we       (ramWe),
      .ram_addr     (ramAddr),
      .ram_wdata    (ramWdata),
      .ram_rdata    (ramRdata)
   );

   always #5 CLK = ~CLK;

   // Behavioural RAM macro with one-cycle read latency.
   logic [DATA_W-1:0] ramArray [EDGE_NUM];
   always @(posedge CLK) begin
      if (ramEn) begin
         if (ramWe) ramArray[ramAddr] = ramWdata;
         else       ramRdata <= ramArray[ramAddr];
      end
   end

   int testsRun = 0;
   int testsFailed = 0;

   // Stimulus for the next cycle.
   logic [N-1:0]      reqV, lockV, weV;
   logic [ADDR_W-1:0] addrV  [N];
   logic [DATA_W-1:0] wdataV [N];

   // Reference model state.
   logic [DATA_W-1:0] refMem [EDGE_NUM];
   int                mLast, mOwner, mCnt;
   bit                mLocked;
   bit   [N-1:0]      expRvalid;
   bit                expAddrErr, expTimeout;
   logic [DATA_W-1:0] expRdata;
   int                modelG;

   // Values observed in the most recent cycle.
   logic [N-1:0]      lastGnt, lastRvalid;
   logic [DATA_W-1:0] lastRdata;
   logic              lastRamEn, lastAddrErr, lastTimeout;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drives one cycle of stimulus, checks the DUT against the model at the
   // falling edge, advances the model, and leaves time just after the next
   // rising edge.
   task automatic applyStimulus();
      int      g;
      bit      granted, illegal;
      bit [N-1:0] expGnt;
      bus.req  = reqV;
      bus.lock = lockV;
      bus.we   = weV;
      for (int i = 0; i < N; i++) begin
         bus.addr[i*ADDR_W +: ADDR_W]  = addrV[i];
         bus.wdata[i*DATA_W +: DATA_W] = wdataV[i];
      end
      #4;
      g = -1;
      if (RST_n) begin
         if (mLocked && lockV[mOwner] && reqV[mOwner]) begin
            g = mOwner;
         end else begin
            for (int k = 1; k <= N; k++) begin
               if (g < 0 && reqV[(mLast + k) % N]) g = (mLast + k) % N;
            end
         end
      end
      granted = (g >= 0);
      expGnt  = '0;
      if (granted) expGnt[g] = 1'b1;
      illegal = granted && (int'(addrV[g]) >= EDGE_NUM);
      modelG  = g;

      lastGnt     = bus.gnt;
      lastRvalid  = bus.rvalid;
      lastRdata   = bus.rdata;
      lastRamEn   = ramEn;
      lastAddrErr = addrErr;
      lastTimeout = lockTimeout;

      checkOutput("gnt", 32'(bus.gnt), 32'(expGnt));
      checkOutput("ram_en", 32'(ramEn), 32'(granted && !illegal));
      if (granted && !illegal) begin
         checkOutput("ram_we", 32'(ramWe), 32'(weV[g]));
         checkOutput("ram_addr", 32'(ramAddr), 32'(addrV[g]));
         if (weV[g]) checkOutput("ram_wdata", 32'(ramWdata), 32'(wdataV[g]));
      end
      checkOutput("rvalid", 32'(bus.rvalid), RST_n ? 32'(expRvalid) : 32'd0);
      if (RST_n && expRvalid != 0) checkOutput("rdata", 32'(bus.rdata), 32'(expRdata));
      checkOutput("addr_err", 32'(addrErr), 32'(RST_n && expAddrErr));
      checkOutput("lock_timeout", 32'(lockTimeout), 32'(RST_n && expTimeout));

      if (!RST_n) begin
         mLast = N - 1; mLocked = 0; mOwner = 0; mCnt = 0;
         expRvalid = '0; expAddrErr = 0; expTimeout = 0;
      end else begin
         expRvalid  = '0;
         expAddrErr = illegal;
         expTimeout = 0;
         if (granted && !illegal) begin
            if (weV[g]) refMem[addrV[g]] = wdataV[g];
            else begin
               expRvalid[g] = 1'b1;
               expRdata     = refMem[addrV[g]];
            end
         end
         if (mLocked) begin
            if (!lockV[mOwner]) begin
               mLocked = 0; mCnt = 0;
               if (granted && lockV[g]) begin mLocked = 1; mOwner = g; end
            end else if (mCnt == LOCK_MAX - 1) begin
               mLocked = 0; mCnt = 0; expTimeout = 1;
            end else begin
               mCnt++;
            end
         end else if (granted && lockV[g]) begin
            mLocked = 1; mOwner = g; mCnt = 0;
         end
         if (granted) mLast = g;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic setIdle();
      reqV = '0; lockV = '0; weV = '0;
      for (int i = 0; i < N; i++) begin addrV[i] = '0; wdataV[i] = '0; end
   endtask

   initial begin
      logic [N-1:0] rotSeq [4];
      int sweepIdx, runLen, maxRun, iter, pulses;
      logic [N-1:0] gntAtPulse;

      for (int i = 0; i < EDGE_NUM; i++) begin
         ramArray[i] = DATA_W'($urandom);
         refMem[i]   = ramArray[i];
      end
      mLast = N - 1; mLocked = 0; mOwner = 0; mCnt = 0;
      expRvalid = '0; expAddrErr = 0; expTimeout = 0; expRdata = '0;
      setIdle();
      @(posedge CLK); #1;

      // Reset with everybody requesting: nothing may be granted.
      RST_n = 1'b0;
      reqV = 3'b111;
      for (int c = 0; c < 3; c++) applyStimulus();
      checkOutput("resetGnt", 32'(lastGnt), 32'd0);
      RST_n = 1'b1;

      // Rotation of reads across all three requesters.
      rotSeq[0] = 3'b001; rotSeq[1] = 3'b010; rotSeq[2] = 3'b100; rotSeq[3] = 3'b001;
      reqV = 3'b111; weV = '0;
      addrV[0] = 5; addrV[1] = 6; addrV[2] = 7;
      for (int c = 0; c < 4; c++) begin
         applyStimulus();
         checkOutput("rotation", 32'(lastGnt), 32'(rotSeq[c]));
      end
      setIdle();
      applyStimulus();
      checkOutput("rotationRvalid", 32'(lastRvalid), 32'(3'b001));

      // Host write followed by graph-search read of the same word.
      reqV = 3'b001; weV = 3'b001; addrV[0] = 12; wdataV[0] = 16'h0A1B;
      applyStimulus();
      setIdle();
      reqV = 3'b100; addrV[2] = 12;
      applyStimulus();
      setIdle();
      applyStimulus();
      checkOutput("wrRdRvalid", 32'(lastRvalid), 32'(3'b100));
      checkOutput("wrRdData", 32'(lastRdata), 32'h0A1B);

      // Write to the first illegal address, then read back word 1033.
      reqV = 3'b001; weV = 3'b001; addrV[0] = ADDR_W'(EDGE_NUM); wdataV[0] = 16'hFFFF;
      applyStimulus();
      checkOutput("illegalGnt", 32'(lastGnt), 32'(3'b001));
      checkOutput("illegalRamEn", 32'(lastRamEn), 32'd0);
      setIdle();
      reqV = 3'b001; addrV[0] = ADDR_W'(EDGE_NUM - 1);
      applyStimulus();
      checkOutput("illegalAddrErr", 32'(lastAddrErr), 32'd1);
      setIdle();
      applyStimulus();

      // Graph search locks and sweeps the full RAM while the collision
      // checker requests continuously.
      reqV = 3'b100; lockV = 3'b100; addrV[2] = 0;
      sweepIdx = 0; runLen = 0; maxRun = 0; iter = 0;
      applyStimulus();
      if (lastGnt == 3'b100) runLen = 1;
      if (modelG == 2) sweepIdx++;
      reqV = 3'b110;
      while (sweepIdx < EDGE_NUM && iter < 3000) begin
         addrV[2] = ADDR_W'(sweepIdx);
         addrV[1] = ADDR_W'($urandom_range(0, EDGE_NUM - 1));
         applyStimulus();
         if (lastGnt == 3'b100) runLen++;
         else runLen = 0;
         if (runLen > maxRun) maxRun = runLen;
         if (modelG == 2) sweepIdx++;
         iter++;
      end
      checkOutput("sweepBound", 32'(iter < 3000), 32'd1);
      checkOutput("sweepRun", 32'(maxRun), 32'(EDGE_NUM));
      reqV = 3'b010; lockV = '0;
      applyStimulus();
      checkOutput("sweepRelease", 32'(lastGnt), 32'(3'b010));

      // Collision checker holds its lock past the limit; graph search waits.
      setIdle();
      reqV = 3'b010; lockV = 3'b010; addrV[1] = 40; addrV[2] = 41;
      applyStimulus();
      reqV = 3'b110;
      pulses = 0; gntAtPulse = '0;
      for (int c = 0; c < LOCK_MAX + 4; c++) begin
         applyStimulus();
         if (lastTimeout === 1'b1) begin
            pulses++;
            gntAtPulse = lastGnt;
         end
      end
      checkOutput("timeoutPulses", 32'(pulses), 32'd1);
      checkOutput("timeoutNextGnt", 32'(gntAtPulse), 32'(3'b100));

      // Reset asserted while a read is in flight.
      setIdle();
      applyStimulus();
      reqV = 3'b001; addrV[0] = 3;
      applyStimulus();
      RST_n = 1'b0; reqV = 3'b111;
      applyStimulus();
      checkOutput("resetRvalid", 32'(lastRvalid), 32'd0);
      checkOutput("resetGnt2", 32'(lastGnt), 32'd0);
      RST_n = 1'b1;
      applyStimulus();
      checkOutput("postResetGnt", 32'(lastGnt), 32'(3'b001));

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         reqV  = N'($urandom);
         weV   = N'($urandom);
         lockV = '0;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) lockV[i] = reqV[i];
            if ($urandom_range(0, 15) == 0) addrV[i] = ADDR_W'($urandom_range(EDGE_NUM, (1 << ADDR_W) - 1));
            else addrV[i] = ADDR_W'($urandom_range(0, EDGE_NUM - 1));
            wdataV[i] = DATA_W'($urandom);
         end
         if (mLocked && $urandom_range(0, 3) != 0) lockV[mOwner] = 1'b1;
         applyStimulus();
      end
      setIdle();
      applyStimulus();
      applyStimulus();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
